switch_debounce: RTL and testbench

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce_pkg.sv | 18 +
 rtl/debounce_channel.sv | 59 +++++
 rtl/switch_debounce.sv | 49 ++++
 tb/tb_switch_debounce.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// rtl/switch_debounce_pkg.sv - shared constants and types for the switch debouncer
package switch_debounce_pkg;

    // 10 ms of stable level at a 25 MHz system clock
    localparam int DEBOUNCE_LIMIT_DEFAULT = 250000;

    // Number of push-switch channels on the board
    localparam int NUM_CHANNELS = 4;

    // One bit per channel, bit 0 = switch 1
    typedef logic [NUM_CHANNELS-1:0] chan_vec_t;

    // Counter width able to hold 0..limit-1; never narrower than one bit
    function automatic int cnt_width(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one switch channel: synchronizer, stability counter, stable level, edge pulses
module debounce_channel
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Raw,
    output logic o_Level,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int CW = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer: the raw switch is asynchronous to i_Clk
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_Raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive cycles of disagreement; accept the new level on the last one
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt     <= '0;
            o_Level <= 1'b0;
            o_Rise  <= 1'b0;
            o_Fall  <= 1'b0;
        end else begin
            o_Rise <= 1'b0;
            o_Fall <= 1'b0;
            if (sync2 == o_Level) begin
                // Any agreement restarts the count, so bounces never accumulate
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Clearing here is what keeps the counter from ever wrapping
                o_Level <= sync2;
                cnt     <= '0;
                o_Rise  <= sync2;
                o_Fall  <= ~sync2;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - four independent debounced push-switch channels with rise/fall pulses
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_n,
    input  logic                    i_Switch_1,
    input  logic                    i_Switch_2,
    input  logic                    i_Switch_3,
    input  logic                    i_Switch_4,
    output logic                    o_Switch_1,
    output logic                    o_Switch_2,
    output logic                    o_Switch_3,
    output logic                    o_Switch_4,
    output logic [NUM_CHANNELS-1:0] o_Rise,
    output logic [NUM_CHANNELS-1:0] o_Fall
);

    chan_vec_t raw;
    chan_vec_t level;
    chan_vec_t rise;
    chan_vec_t fall;

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_chan (
            .i_Clk   (i_Clk),
            .i_Rst_n (i_Rst_n),
            .i_Raw   (raw[g]),
            .o_Level (level[g]),
            .o_Rise  (rise[g]),
            .o_Fall  (fall[g])
        );
    end

    // Outputs are the channel flops directly; no logic between register and pin
    assign o_Switch_1 = level[0];
    assign o_Switch_2 = level[1];
    assign o_Switch_3 = level[2];
    assign o_Switch_4 = level[3];
    assign o_Rise     = rise;
    assign o_Fall     = fall;

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - self-checking bench for switch_debounce with DEBOUNCE_LIMIT=4
module tb_switch_debounce;

    localparam int LIMIT = 4;
    localparam int LAT   = LIMIT + 2;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] sw;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw   = 4'b0000;
    logic [3:0] sw;
    logic [3:0] rise;
    logic [3:0] fall;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t e;

    switch_debounce #(
        .DEBOUNCE_LIMIT(LIMIT)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Switch_1 (raw[0]),
        .i_Switch_2 (raw[1]),
        .i_Switch_3 (raw[2]),
        .i_Switch_4 (raw[3]),
        .o_Switch_1 (sw[0]),
        .o_Switch_2 (sw[1]),
        .o_Switch_3 (sw[2]),
        .o_Switch_4 (sw[3]),
        .o_Rise     (rise),
        .o_Fall     (fall)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    // Rising-edge counter used to time expected events
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        raw = 4'b1111;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (sw !== 4'b0000) begin errors++; $display("FAIL reset_sw: got %b want 0000", sw); end
            checks++;
            if (rise !== 4'b0000) begin errors++; $display("FAIL reset_rise: got %b want 0000", rise); end
            checks++;
            if (fall !== 4'b0000) begin errors++; $display("FAIL reset_fall: got %b want 0000", fall); end
        end
        raw = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if ((rise | fall) != 4'b0000) begin
                checks++; errors++;
                $display("FAIL reset_release_pulse: got rise=%b fall=%b want none", rise, fall);
            end
        end
        checks++;
        if (sw !== 4'b0000) begin errors++; $display("FAIL reset_release_sw: got %b want 0000", sw); end
    endtask

    task automatic test_clean_press();
        int t0;
        @(negedge clk);
        t0 = cyc;
        raw[0] = 1'b1;
        exp_q.push_back('{t0 + LAT, 4'b0001, 4'b0000, 4'b0001});
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (cyc == t0 + LAT - 1) begin
                checks++;
                if (sw[0] !== 1'b0) begin errors++; $display("FAIL press_early: got %b want 0", sw[0]); end
            end
            if (cyc == t0 + LAT) begin
                checks++;
                if (sw[0] !== 1'b1) begin errors++; $display("FAIL press_level: got %b want 1", sw[0]); end
            end
            if ((rise | fall) != 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL press_pulse: got rise=%b fall=%b at cycle %0d want none", rise, fall, cyc - t0);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || rise !== e.rise || fall !== e.fall || sw !== e.sw) begin
                        errors++;
                        $display("FAIL press_pulse: got cyc=%0d rise=%b fall=%b sw=%b want cyc=%0d rise=%b fall=%b sw=%b",
                                 cyc - t0, rise, fall, sw, e.cyc - t0, e.rise, e.fall, e.sw);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL press_missing: got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_glitch();
        @(negedge clk);
        raw[1] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) raw[1] = 1'b0;
            checks++;
            if (sw !== 4'b0001) begin errors++; $display("FAIL glitch_sw: got %b want 0001", sw); end
            if ((rise | fall) != 4'b0000) begin
                checks++; errors++;
                $display("FAIL glitch_pulse: got rise=%b fall=%b want none", rise, fall);
            end
        end
    endtask

    task automatic test_bounce();
        int t0;
        @(negedge clk);
        t0 = cyc;
        raw[2] = 1'b1;
        exp_q.push_back('{t0 + 4 + LAT, 4'b0100, 4'b0000, 4'b0101});
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (cyc == t0 + 4 + LAT - 1) begin
                checks++;
                if (sw[2] !== 1'b0) begin errors++; $display("FAIL bounce_early: got %b want 0", sw[2]); end
            end
            if (cyc == t0 + 4 + LAT) begin
                checks++;
                if (sw[2] !== 1'b1) begin errors++; $display("FAIL bounce_level: got %b want 1", sw[2]); end
            end
            if ((rise | fall) != 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bounce_pulse: got rise=%b fall=%b at cycle %0d want none", rise, fall, cyc - t0);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || rise !== e.rise || fall !== e.fall || sw !== e.sw) begin
                        errors++;
                        $display("FAIL bounce_pulse: got cyc=%0d rise=%b fall=%b sw=%b want cyc=%0d rise=%b fall=%b sw=%b",
                                 cyc - t0, rise, fall, sw, e.cyc - t0, e.rise, e.fall, e.sw);
                    end
                end
            end
            if (i == 1) raw[2] = 1'b0;
            if (i == 2) raw[2] = 1'b1;
            if (i == 3) raw[2] = 1'b0;
            if (i == 4) raw[2] = 1'b1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bounce_missing: got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_release();
        int t0;
        @(negedge clk);
        t0 = cyc;
        raw = 4'b1111;
        exp_q.push_back('{t0 + LAT, 4'b1010, 4'b0000, 4'b1111});
        exp_q.push_back('{t0 + 8 + LAT, 4'b0000, 4'b1111, 4'b0000});
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (cyc == t0 + 8 + LAT - 1) begin
                checks++;
                if (sw !== 4'b1111) begin errors++; $display("FAIL release_early: got %b want 1111", sw); end
            end
            if (cyc == t0 + 8 + LAT) begin
                checks++;
                if (sw !== 4'b0000) begin errors++; $display("FAIL release_level: got %b want 0000", sw); end
            end
            if ((rise | fall) != 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL release_pulse: got rise=%b fall=%b at cycle %0d want none", rise, fall, cyc - t0);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || rise !== e.rise || fall !== e.fall || sw !== e.sw) begin
                        errors++;
                        $display("FAIL release_pulse: got cyc=%0d rise=%b fall=%b sw=%b want cyc=%0d rise=%b fall=%b sw=%b",
                                 cyc - t0, rise, fall, sw, e.cyc - t0, e.rise, e.fall, e.sw);
                    end
                end
            end
            if (i == 8) raw = 4'b0000;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL release_missing: got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_count();
        int t0;
        @(negedge clk);
        t0 = cyc;
        raw[0] = 1'b1;
        exp_q.push_back('{t0 + LAT, 4'b0001, 4'b0000, 4'b0001});
        exp_q.push_back('{t0 + 11 + LAT, 4'b1001, 4'b0000, 4'b1001});
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            if (rst_n === 1'b0) begin
                checks++;
                if (sw !== 4'b0000) begin errors++; $display("FAIL midrst_hold: got %b want 0000", sw); end
            end
            if (cyc == t0 + 11 + LAT - 1) begin
                checks++;
                if (sw !== 4'b0000) begin errors++; $display("FAIL midrst_early: got %b want 0000", sw); end
            end
            if (cyc == t0 + 11 + LAT) begin
                checks++;
                if (sw !== 4'b1001) begin errors++; $display("FAIL midrst_level: got %b want 1001", sw); end
            end
            if ((rise | fall) != 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL midrst_pulse: got rise=%b fall=%b at cycle %0d want none", rise, fall, cyc - t0);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || rise !== e.rise || fall !== e.fall || sw !== e.sw) begin
                        errors++;
                        $display("FAIL midrst_pulse: got cyc=%0d rise=%b fall=%b sw=%b want cyc=%0d rise=%b fall=%b sw=%b",
                                 cyc - t0, rise, fall, sw, e.cyc - t0, e.rise, e.fall, e.sw);
                    end
                end
            end
            if (i == 8) raw[3] = 1'b1;
            if (i == 10) begin
                checks++;
                if (sw !== 4'b0001) begin errors++; $display("FAIL midrst_before: got %b want 0001", sw); end
                #2;
                rst_n = 1'b0;
                #1;
                checks++;
                if ({sw, rise, fall} !== 12'h000) begin
                    errors++;
                    $display("FAIL midrst_async: got sw=%b rise=%b fall=%b want all 0", sw, rise, fall);
                end
            end
            if (i == 11) rst_n = 1'b1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_missing: got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    // Scenario sequence followed by the single summary line
    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_release();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
